// File: rtl/kbd_ctrl_fsm_if.sv
// Transport-control bundle between the PS/2 key front end and the decoder.
interface kbd_ctrl_fsm_if #(
  parameter int RATE_W = 4
);
  logic [7:0]        key;
  logic              playpause;
  logic              dir;
  logic [RATE_W-1:0] rate;
  logic              restart;
  logic              cmd_strobe;

  modport master (output key, input playpause, dir, rate, restart, cmd_strobe);
  modport slave  (input key, output playpause, dir, rate, restart, cmd_strobe);
endinterface

// File: rtl/kbd_ctrl_fsm.sv
// Keyboard command decoder: edge-detected key codes drive a transport FSM,
// a saturating rate register with hold-to-repeat, and a restart pulse.
module kbd_ctrl_fsm #(
  parameter int             RATE_W      = 4,
  parameter int             RATE_MIN    = 1,
  parameter int             RATE_MAX    = 15,
  parameter int             RATE_DEF    = 8,
  parameter int             RPT_W       = 24,
  parameter int             REPEAT_CYC  = 2500000,
  parameter logic [7:0]     KEY_PLAY    = 8'h45,
  parameter logic [7:0]     KEY_PAUSE   = 8'h44,
  parameter logic [7:0]     KEY_FWD     = 8'h46,
  parameter logic [7:0]     KEY_REV     = 8'h42,
  parameter logic [7:0]     KEY_RESTART = 8'h52,
  parameter logic [7:0]     KEY_FASTER  = 8'h55,
  parameter logic [7:0]     KEY_SLOWER  = 8'h4E,
  parameter logic [7:0]     KEY_RATERST = 8'h54
) (
  input  logic         clk,
  input  logic         rst,
  kbd_ctrl_fsm_if.slave bus
);

  // Encoding is {dir, playpause} so the outputs come straight off the state.
  typedef enum logic [1:0] {
    PAUSE_REV = 2'b00,
    PLAY_REV  = 2'b01,
    PAUSE_FWD = 2'b10,
    PLAY_FWD  = 2'b11
  } state_t;

  localparam logic [RATE_W-1:0] R_MIN = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] R_MAX = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] R_DEF = RATE_W'(RATE_DEF);
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  state_t            state, state_d;
  logic [7:0]        key_q;
  logic [RATE_W-1:0] rate_q, rate_d, rate_up, rate_dn;
  logic [RPT_W-1:0]  rpt_cnt, rpt_d;
  logic              restart_q, restart_d, strobe_q, strobe_d;
  logic              is_new, is_rate_key, held_rate;

  assign is_new      = (bus.key != key_q) && (bus.key != 8'h00);
  assign is_rate_key = (bus.key == KEY_FASTER) || (bus.key == KEY_SLOWER);
  assign held_rate   = (REPEAT_CYC > 0) && is_rate_key && (bus.key == key_q);
  assign rate_up     = (rate_q >= R_MAX) ? R_MAX : rate_q + RATE_W'(1);
  assign rate_dn     = (rate_q <= R_MIN) ? R_MIN : rate_q - RATE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY_FWD;
      key_q     <= 8'h00;
      rate_q    <= R_DEF;
      rpt_cnt   <= '0;
      restart_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state     <= state_d;
      key_q     <= bus.key;
      rate_q    <= rate_d;
      rpt_cnt   <= rpt_d;
      restart_q <= restart_d;
      strobe_q  <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state;
    rate_d    = rate_q;
    rpt_d     = '0;
    restart_d = 1'b0;
    strobe_d  = 1'b0;

    case (state)
      PLAY_FWD:  if (is_new && bus.key == KEY_PAUSE) state_d = PAUSE_FWD;
                 else if (is_new && bus.key == KEY_REV) state_d = PLAY_REV;
      PAUSE_FWD: if (is_new && bus.key == KEY_PLAY) state_d = PLAY_FWD;
                 else if (is_new && bus.key == KEY_REV) state_d = PAUSE_REV;
      PLAY_REV:  if (is_new && bus.key == KEY_PAUSE) state_d = PAUSE_REV;
                 else if (is_new && bus.key == KEY_FWD) state_d = PLAY_FWD;
      PAUSE_REV: if (is_new && bus.key == KEY_PLAY) state_d = PLAY_REV;
                 else if (is_new && bus.key == KEY_FWD) state_d = PAUSE_FWD;
      default:   state_d = PLAY_FWD;
    endcase

    if (is_new) begin
      case (bus.key)
        KEY_PLAY, KEY_PAUSE, KEY_FWD, KEY_REV: strobe_d = 1'b1;
        KEY_RESTART: begin
          state_d   = state_t'({state[1], 1'b1});
          restart_d = 1'b1;
          strobe_d  = 1'b1;
        end
        KEY_FASTER:  begin rate_d = rate_up; strobe_d = 1'b1; end
        KEY_SLOWER:  begin rate_d = rate_dn; strobe_d = 1'b1; end
        KEY_RATERST: begin rate_d = R_DEF;   strobe_d = 1'b1; end
        default: ;
      endcase
    end else if (held_rate) begin
      // Counter reaching RPT_LAST marks REPEAT_CYC cycles since the last step.
      if (rpt_cnt == RPT_LAST) begin
        rate_d   = (bus.key == KEY_FASTER) ? rate_up : rate_dn;
        strobe_d = 1'b1;
      end else begin
        rpt_d = rpt_cnt + RPT_W'(1);
      end
    end
  end

  assign bus.playpause  = state[0];
  assign bus.dir        = state[1];
  assign bus.rate       = rate_q;
  assign bus.restart    = restart_q;
  assign bus.cmd_strobe = strobe_q;

endmodule

// File: tb/tb_kbd_ctrl_fsm.sv
// Directed bench for kbd_ctrl_fsm with a key-history model checked every cycle.
module tb_kbd_ctrl_fsm;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  kbd_ctrl_fsm_if #(.RATE_W(4)) bus ();

  kbd_ctrl_fsm #(.RATE_W(4), .RATE_MIN(1), .RATE_MAX(15), .RATE_DEF(8),
                 .RPT_W(24), .REPEAT_CYC(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: each output is a function of key history; repeat steps fall on
  // every RC-th held edge after the press.
  int m_play, m_fwd, m_rate, m_restart, m_strobe, m_hold;
  logic [7:0] m_prev;

  always @(posedge clk) begin
    if (rst) begin
      m_play = 1; m_fwd = 1; m_rate = 8; m_restart = 0; m_strobe = 0;
      m_prev = 8'h00; m_hold = 0;
    end else begin
      m_restart = 0; m_strobe = 0;
      if (bus.key != m_prev && bus.key != 8'h00) begin
        m_hold = 0;
        case (bus.key)
          8'h45: begin m_play = 1; m_strobe = 1; end
          8'h44: begin m_play = 0; m_strobe = 1; end
          8'h46: begin m_fwd = 1; m_strobe = 1; end
          8'h42: begin m_fwd = 0; m_strobe = 1; end
          8'h52: begin m_play = 1; m_restart = 1; m_strobe = 1; end
          8'h55: begin m_rate = (m_rate + 1 > 15) ? 15 : m_rate + 1; m_strobe = 1; end
          8'h4E: begin m_rate = (m_rate - 1 < 1) ? 1 : m_rate - 1; m_strobe = 1; end
          8'h54: begin m_rate = 8; m_strobe = 1; end
          default: ;
        endcase
      end else if (bus.key == m_prev && (bus.key == 8'h55 || bus.key == 8'h4E)) begin
        m_hold++;
        if (m_hold % RC == 0) begin
          m_strobe = 1;
          if (bus.key == 8'h55) m_rate = (m_rate + 1 > 15) ? 15 : m_rate + 1;
          else                  m_rate = (m_rate - 1 < 1) ? 1 : m_rate - 1;
        end
      end
      m_prev = bus.key;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_playpause", int'(bus.playpause), m_play);
      chk("mdl_dir", int'(bus.dir), m_fwd);
      chk("mdl_rate", int'(bus.rate), m_rate);
      chk("mdl_restart", int'(bus.restart), m_restart);
      chk("mdl_strobe", int'(bus.cmd_strobe), m_strobe);
    end
  end

  task automatic step(input logic [7:0] k);
    bus.key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    step(k);
    step(8'h00);
  endtask

  int cnt;

  initial begin
    bus.key = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(8'h00);
    rst = 1'b0;
    chk("rst_playpause", int'(bus.playpause), 1);
    chk("rst_dir", int'(bus.dir), 1);
    chk("rst_rate", int'(bus.rate), 8);
    chk("rst_strobe", int'(bus.cmd_strobe), 0);

    // Pause then reverse
    step(8'h44);
    chk("pause_pp", int'(bus.playpause), 0);
    chk("pause_dir", int'(bus.dir), 1);
    chk("pause_strobe", int'(bus.cmd_strobe), 1);
    step(8'h42);
    chk("rev_pp", int'(bus.playpause), 0);
    chk("rev_dir", int'(bus.dir), 0);
    step(8'h00);

    // Restart held 10 cycles from PAUSE_REV
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'h52);
      if (i == 0) begin
        chk("rst_key_pp", int'(bus.playpause), 1);
        chk("rst_key_dir", int'(bus.dir), 0);
      end
      cnt += int'(bus.restart);
    end
    chk("restart_pulses", cnt, 1);
    step(8'h00);

    // Hold FASTER 13 cycles: steps at edges 1,5,9,13
    cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      step(8'h55);
      cnt += int'(bus.cmd_strobe);
      if (i == 1)  chk("rpt_e1", int'(bus.rate), 9);
      if (i == 4)  chk("rpt_e4", int'(bus.rate), 9);
      if (i == 5)  chk("rpt_e5", int'(bus.rate), 10);
      if (i == 9)  chk("rpt_e9", int'(bus.rate), 11);
      if (i == 13) chk("rpt_e13", int'(bus.rate), 12);
    end
    chk("rpt_strobes", cnt, 4);
    step(8'h00);

    // Saturation at the ceiling
    press(8'h55);
    press(8'h55);
    chk("rate14", int'(bus.rate), 14);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(8'h55);
      cnt += int'(bus.cmd_strobe);
      chk("sat_hi", int'(bus.rate), 15);
      step(8'h00);
    end
    chk("sat_hi_strobes", cnt, 3);
    step(8'h54);
    chk("raterst", int'(bus.rate), 8);
    step(8'h00);
    for (int i = 0; i < 10; i++) press(8'h4E);
    chk("sat_lo", int'(bus.rate), 1);

    // Repeated pause presses, then an unknown code
    press(8'h46);
    step(8'h44);
    chk("p1_pp", int'(bus.playpause), 0);
    chk("p1_strobe", int'(bus.cmd_strobe), 1);
    step(8'h44);
    chk("hold_strobe", int'(bus.cmd_strobe), 0);
    step(8'h00);
    step(8'h44);
    chk("p2_pp", int'(bus.playpause), 0);
    chk("p2_dir", int'(bus.dir), 1);
    chk("p2_strobe", int'(bus.cmd_strobe), 1);
    step(8'h41);
    chk("unk_strobe", int'(bus.cmd_strobe), 0);
    chk("unk_pp", int'(bus.playpause), 0);
    step(8'h00);

    // Reset while FASTER is held mid-repeat
    for (int i = 0; i < 6; i++) step(8'h55);
    chk("pre_rst_rate", int'(bus.rate), 3);
    rst = 1'b1;
    step(8'h55);
    step(8'h55);
    chk("mid_rst_rate", int'(bus.rate), 8);
    chk("mid_rst_pp", int'(bus.playpause), 1);
    chk("mid_rst_dir", int'(bus.dir), 1);
    rst = 1'b0;
    step(8'h55);
    chk("post_rst_rate", int'(bus.rate), 9);
    chk("post_rst_strobe", int'(bus.cmd_strobe), 1);
    for (int i = 2; i <= 5; i++) begin
      step(8'h55);
      if (i == 4) chk("post_rst_e4", int'(bus.rate), 9);
      if (i == 5) chk("post_rst_e5", int'(bus.rate), 10);
    end
    step(8'h00);
    step(8'h00);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
